// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Program loader behind the SoC debug pin. While uart_debug_pin is high it
//   holds the core in halt and decodes a framed image from an 8N1 UART byte
//   stream. The frame is 0x55, a 16-bit little-endian word count N, 4*N data
//   bytes (little-endian words), and an 8-bit sum of the data bytes. Each
//   completed word is written into instruction ROM through a one-cycle strobe.
//
// Ports
//   clk             in   1   core clock
//   rst             in   1   synchronous reset, active-low
//   uart_debug_pin  in   1   1 = loader enabled
//   uart_rx         in   1   asynchronous serial input, idle high
//   halt_o          out  1   1 = hold the core pipeline (registered)
//   mem_we_o        out  1   one-cycle ROM write strobe
//   mem_addr_o      out  32  ROM byte address, held until the next write
//   mem_wdata_o     out  32  ROM write data, held until the next write
//   load_done_o     out  1   image accepted with a good checksum
//   load_err_o      out  1   framing, length or checksum error
module uart_prog_loader #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_debug_pin,
    input  logic        uart_rx,
    output logic        halt_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int          CNT_W = $clog2(DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    // Receiver state
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;

    // Frame decoder state and datapath
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        halt_q, halt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [15:0] len_full;
    logic        active_state;

    // The count is only complete once the high byte arrives in LEN1.
    assign len_full     = {rx_shift_q, len_q[7:0]};
    assign active_state = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

    // Bit-level receiver: start bit re-checked at mid-bit, then data and stop
    // bits sampled one bit time apart. A bad stop bit yields a one-cycle error
    // pulse instead of a byte.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_W'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_W'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_W'(DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame decoder next state. Dropping the debug pin mid-load abandons the
    // frame silently; a framing error during a load is fatal for the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (uart_debug_pin) state_d = SYNC;
            DONE, ERR: if (!uart_debug_pin) state_d = IDLE;
            default: begin
                if (!uart_debug_pin) begin
                    state_d = IDLE;
                end else if (rx_ferr_q) begin
                    state_d = ERR;
                end else if (rx_valid_q) begin
                    case (state_q)
                        SYNC: if (rx_shift_q == 8'h55) state_d = LEN0;
                        LEN0: state_d = LEN1;
                        LEN1: begin
                            if (32'(len_full) > MAX_WORDS) state_d = ERR;
                            else if (len_full == 16'd0)   state_d = CSUM;
                            else                          state_d = DATA;
                        end
                        DATA: begin
                            if (byte_cnt_q == 2'd3 && idx_q == len_q - 16'd1) begin
                                state_d = CSUM;
                            end
                        end
                        CSUM: state_d = (rx_shift_q == csum_q) ? DONE : ERR;
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
    end

    // Datapath and registered outputs. The write strobe is computed in the
    // rx_valid cycle of byte b3 so it appears on the port one clock later.
    always_comb begin
        len_d       = len_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halt_d      = (state_d != IDLE);
        if (active_state && uart_debug_pin && rx_valid_q) begin
            case (state_q)
                LEN0: len_d[7:0] = rx_shift_q;
                LEN1: begin
                    len_d      = len_full;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                end
                DATA: begin
                    csum_d     = csum_q + rx_shift_q;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = rx_shift_q;
                        2'd1: word_d[15:8]  = rx_shift_q;
                        2'd2: word_d[23:16] = rx_shift_q;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                            mem_wdata_d = {rx_shift_q, word_q};
                            idx_d       = idx_q + 16'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // All state registers. The synchroniser resets to the idle-high line
    // level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_ferr_q   <= 1'b0;
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            halt_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            rx_ferr_q   <= rx_ferr_d;
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            halt_q      <= halt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign halt_o      = halt_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign load_done_o = (state_q == DONE);
    assign load_err_o  = (state_q == ERR);

endmodule
